// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-input, WIDTH-bit valid/ready stream multiplexer with a
// single registered output stage. Channel choice is either a fixed select
// (mode=0) or round-robin starting at rr_ptr (mode=1). The data path is a row
// of SLICE_W-bit N:1 slice muxes that all share one grant index.
// Optional build macro STREAM_MUX_PKT_LOCK_EN adds in_last/out_last and holds
// the grant on one channel until that channel sends its last beat.

// One SLICE_W-bit N:1 mux; the index is always a legal channel when the
// result is used.
module stream_mux_slice #(
    parameter int N_CH    = 4,
    parameter int SLICE_W = 2,
    parameter int CW      = $clog2(N_CH)
) (
    input  logic [N_CH-1:0][SLICE_W-1:0] din,
    input  logic [CW-1:0]                idx,
    output logic [SLICE_W-1:0]           dout
);
    assign dout = din[idx];
endmodule

module stream_mux_rr #(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 8,
    parameter int SLICE_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [$clog2(N_CH)-1:0]   sel,
    input  logic [N_CH-1:0]           in_valid,
    output logic [N_CH-1:0]           in_ready,
    input  logic [N_CH*WIDTH-1:0]     in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [N_CH-1:0]           in_last,
    output logic                      out_last,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(N_CH)-1:0]   out_ch
);
    localparam int CW  = $clog2(N_CH);
    localparam int NSL = WIDTH / SLICE_W;

    // A partial slice would silently drop data bits, so refuse to elaborate.
    if (WIDTH % SLICE_W != 0) begin : g_bad_width
        $error("stream_mux_rr: WIDTH must be a multiple of SLICE_W");
    end

    logic [CW-1:0]                rr_ptr;
    logic [CW-1:0]                grant;
    logic                         grant_vld;
    logic                         load_en;
    logic                         xfer;
    logic                         sel_ok;
    logic                         rr_adv;
    logic [CW-1:0]                rr_nxt;
    logic [CW-1:0]                rr_cand;
    int                           rr_t;
    logic [NSL-1:0][SLICE_W-1:0]  mux_slices;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic                         lock_act;
    logic [CW-1:0]                lock_ch;
`endif

    // Output register can take a beat when empty or when its beat leaves now.
    assign load_en = !out_valid || out_ready;
    assign xfer    = grant_vld && load_en;

    // Widened compare so non-power-of-two channel counts reject unused codes.
    assign sel_ok  = (5'(sel) < 5'(N_CH));
    assign rr_nxt  = (grant == CW'(N_CH - 1)) ? '0 : grant + CW'(1);

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Pointer moves only when a packet closes.
    assign rr_adv  = xfer && mode && in_last[grant];
`else
    assign rr_adv  = xfer && mode;
`endif

    // Combinational grant: fixed select or first valid channel from rr_ptr;
    // an open packet overrides both.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        rr_t      = 0;
        rr_cand   = '0;
        if (mode) begin
            for (int k = 0; k < N_CH; k++) begin
                rr_t = int'(rr_ptr) + k;
                if (rr_t >= N_CH) rr_t = rr_t - N_CH;
                rr_cand = CW'(rr_t);
                if (!grant_vld && in_valid[rr_cand]) begin
                    grant_vld = 1'b1;
                    grant     = rr_cand;
                end
            end
        end else if (sel_ok && in_valid[sel]) begin
            grant_vld = 1'b1;
            grant     = sel;
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_act) begin
            grant_vld = in_valid[lock_ch];
            grant     = lock_ch;
        end
`endif
    end

    // Only the granted channel sees ready, and nobody does while in reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = !rst && grant_vld && load_en && (grant == CW'(i));
        end
    end

    for (genvar s = 0; s < NSL; s++) begin : g_slice
        logic [N_CH-1:0][SLICE_W-1:0] din;
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            assign din[c] = in_data[c*WIDTH + s*SLICE_W +: SLICE_W];
        end
        stream_mux_slice #(
            .N_CH    (N_CH),
            .SLICE_W (SLICE_W),
            .CW      (CW)
        ) u_slice (
            .din  (din),
            .idx  (grant),
            .dout (mux_slices[s])
        );
    end

    // Output stage: load on transfer, drain when consumer takes without refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_slices;
            out_ch    <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer: next scan starts just past the last winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_ptr <= '0;
        else if (rr_adv) rr_ptr <= rr_nxt;
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Packet lock: every accepted beat either opens/keeps or closes the lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_act <= 1'b0;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else if (xfer) begin
            lock_act <= !in_last[grant];
            lock_ch  <= grant;
            out_last <= in_last[grant];
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N_CH=4, WIDTH=8, SLICE_W=2).
// A reference model predicts grants and pushes expected beats into a queue;
// beats are popped and compared as the DUT presents them.
module tb_stream_mux_rr;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode = 1'b0;
    logic [CW-1:0]  sel = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_ch;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [N-1:0]   in_last = '0;
    logic           out_last;
`endif

    stream_mux_rr #(.N_CH(N), .WIDTH(W), .SLICE_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          last;
        logic [CW-1:0] ch;
        logic [W-1:0]  data;
    } beat_t;

    beat_t         q[$];
    int            seq[$];
    int            checks = 0;
    int            failures = 0;

    logic          m_valid = 1'b0;
    logic [CW-1:0] m_rr = '0;
    logic [CW-1:0] m_ch = '0;
    logic [W-1:0]  m_data = '0;
    logic          m_lock = 1'b0;
    logic [CW-1:0] m_lck = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int mgrant();
        int g = -1;
        int c;
        if (mode) begin
            for (int k = 0; k < N; k++) begin
                c = (int'(m_rr) + k) % N;
                if (g < 0 && in_valid[c]) g = c;
            end
        end else if (int'(sel) < N && in_valid[sel]) begin
            g = int'(sel);
        end
        if (m_lock) g = in_valid[m_lck] ? int'(m_lck) : -1;
        return g;
    endfunction

    // One cycle: called at a falling edge after inputs are set.
    task automatic tick();
        int           g;
        logic         ld;
        logic         xf;
        logic         lst;
        logic [N-1:0] exp_rdy;
        beat_t        b;
        #1;
        g       = mgrant();
        ld      = !m_valid || out_ready;
        xf      = (g >= 0) && ld;
        exp_rdy = xf ? N'(1 << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        lst = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (xf) lst = in_last[g];
`endif
        if (xf) begin
            b.last = lst;
            b.ch   = CW'(g);
            b.data = in_data[g*W +: W];
            q.push_back(b);
        end
        @(posedge clk);
        if (xf) begin
            m_valid = 1'b1;
            m_ch    = CW'(g);
            m_data  = b.data;
            if (mode && lst) m_rr = CW'((g + 1) % N);
`ifdef STREAM_MUX_PKT_LOCK_EN
            m_lock = !lst;
            m_lck  = CW'(g);
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (xf) begin
            b = q.pop_front();
            chk("beat_ch", 32'(out_ch), 32'(b.ch));
            chk("beat_data", 32'(out_data), 32'(b.data));
`ifdef STREAM_MUX_PKT_LOCK_EN
            chk("beat_last", 32'(out_last), 32'(b.last));
`endif
            seq.push_back(int'(out_ch));
        end else if (m_valid) begin
            chk("hold_ch", 32'(out_ch), 32'(m_ch));
            chk("hold_data", 32'(out_data), 32'(m_data));
        end
    endtask

    task automatic chk_seq(input string tag, input int exp[]);
        chk({tag, "_cnt"}, 32'(seq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < seq.size(); i++)
            chk(tag, 32'(seq[i]), 32'(exp[i]));
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_rr    = '0;
        m_ch    = '0;
        m_data  = '0;
        m_lock  = 1'b0;
        m_lck   = '0;
        q.delete();
    endtask

    initial begin
        int e_rr[]   = '{0, 1, 2, 3, 0, 1, 2, 3};
        int e_odd[]  = '{1, 3, 1, 3};
`ifdef STREAM_MUX_PKT_LOCK_EN
        int e_lock[] = '{1, 1, 1, 2};
`endif
        // Reset state
        in_valid = 4'b1111;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ch", 32'(out_ch), 0);
        chk("rst_rdy", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Round-robin, all valid
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        seq.delete();
        repeat (8) begin in_data = $urandom(); tick(); end
        chk_seq("rr_seq", e_rr);

        // Round-robin, only ch1 and ch3
        in_valid = 4'b1010;
        seq.delete();
        repeat (4) begin in_data = $urandom(); tick(); end
        chk_seq("rr_odd", e_odd);

        // Fixed select on ch2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
        repeat (3) begin
            in_data = $urandom();
            in_data[23:16] = 8'hA5;
            tick();
            chk("fix_rdy", 32'(in_ready), 32'b0100);
            chk("fix_data", 32'(out_data), 32'hA5);
            chk("fix_ch", 32'(out_ch), 2);
        end

        // Backpressure then same-edge replacement
        sel = 2'd0; in_valid = 4'b0001;
        in_data = $urandom(); in_data[7:0] = 8'h3C;
        tick();
        out_ready = 1'b0;
        repeat (3) begin
            in_data = $urandom();
            tick();
            chk("bp_data", 32'(out_data), 32'h3C);
            chk("bp_rdy", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        in_data[7:0] = 8'h5A;
        tick();
        chk("nb_valid", 32'(out_valid), 1);
        chk("nb_data", 32'(out_data), 32'h5A);

        // Pointer wrap: rr_ptr to 3 via ch2, then ch0 wins, pointer lands on 1
        mode = 1'b1;
        in_valid = 4'b0100; in_data = $urandom(); tick();
        in_valid = 4'b0001; in_data = $urandom(); tick();
        chk("wrap_ch", 32'(out_ch), 0);
        in_valid = 4'b1111; in_data = $urandom(); tick();
        chk("wrap_rr", 32'(out_ch), 1);

        // Fixed select on an idle channel: output drains and holds data
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1011;
        tick();
        chk("idle_valid", 32'(out_valid), 0);
        tick();
        chk("idle_valid2", 32'(out_valid), 0);
        chk("idle_hold", 32'(out_data), 32'(m_data));

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Packet lock: ch1 sends 3 beats while ch0/ch2 compete
        mode = 1'b1; in_valid = 4'b0001; in_data = $urandom(); tick();
        seq.delete();
        in_valid = 4'b0111; in_last = 4'b0000; in_data = $urandom(); tick();
        mode = 1'b0; sel = 2'd0; in_data = $urandom(); tick();
        in_valid = 4'b0101; in_data = $urandom(); tick();
        chk("lk_gap", 32'(in_ready), 0);
        in_valid = 4'b0111; mode = 1'b1; in_last = 4'b0010; in_data = $urandom(); tick();
        in_last = 4'b0000; in_data = $urandom(); tick();
        chk_seq("lk_seq", e_lock);
`endif

        // Asynchronous reset with a beat held
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = $urandom() | 32'h0101_0101; tick();
        out_ready = 1'b0; tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_ch", 32'(out_ch), 0);
        chk("arst_rdy", 32'(in_ready), 0);
        @(posedge clk);
        #1 chk("arst_rdy2", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1; in_data = $urandom(); tick();
        chk("post_rst_ch", 32'(out_ch), 0);

        chk("q_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
